// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; V exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic [WIDTH-1:0] Y;
    logic             Co;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             V;
`endif

    modport master (
        output start, A, B, Ci,
`ifdef SERIAL_ADDER_OVF_EN
        input  V,
`endif
        input  Y, Co, busy, done
    );

    modport slave (
        input  start, A, B, Ci,
`ifdef SERIAL_ADDER_OVF_EN
        output V,
`endif
        output Y, Co, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, WIDTH cycles per sum, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output V.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  sa_if
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, y_q;
    logic [CW-1:0]    cnt;
    logic             c_q, co_q;
    logic             sum, cout, last;
    logic             busy_c, done_c;

    assign sum  = a_sr[0] ^ b_sr[0] ^ c_q;
    assign cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE:  if (sa_if.start) state_d = SHIFT;
            SHIFT: begin
                busy_c = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // a_sr doubles as the result register: sum bits enter at the MSB as operand bits leave at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            y_q  <= '0;
            co_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (sa_if.start) begin
                    a_sr <= sa_if.A;
                    b_sr <= sa_if.B;
                    c_q  <= sa_if.Ci;
                    cnt  <= '0;
                end
                SHIFT: begin
                    a_sr <= {sum, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    c_q  <= cout;
                    if (last) begin
                        y_q  <= {sum, a_sr[WIDTH-1:1]};
                        co_q <= cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic v_q;

    // c_q on the final slice is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)                        v_q <= 1'b0;
        else if (state_q == SHIFT && last) v_q <= c_q ^ cout;
    end

    assign sa_if.V = v_q;
`endif

    assign sa_if.Y    = y_q;
    assign sa_if.Co   = co_q;
    assign sa_if.busy = busy_c;
    assign sa_if.done = done_c;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  first operand; captured on the accepting edge.
REQ-006 Port: B  input  WIDTH  second operand; captured on the accepting edge.
REQ-007 Port: Ci  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: Y  output  WIDTH  registered sum A+B+Ci, low WIDTH bits.
REQ-009 Port: Co  output  1  registered carry-out of bit WIDTH-1.
REQ-010 Port: busy  output  1  high while in SHIFT state.
REQ-011 Port: done  output  1  one-cycle pulse; Y/Co valid and updated.

Function
REQ-012 The design SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge k: capture A, B, Ci into internal shift/carry registers, clear bit counter, go to SHIFT.
REQ-014 SHIFT: each edge SHALL process one bit LSB-first using one full-adder slice: sum = a^b^c, carry = majority(a,b,c); carry register updated, sum bit shifted into internal result register.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 (edge k+WIDTH) SHALL load Y and Co and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then go to IDLE; latency from accepting edge to done high = WIDTH cycles; start-to-start minimum spacing = WIDTH+2 cycles.
REQ-017 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-018 A, B, Ci SHALL be don't-care except on the accepting edge.
REQ-019 Y and Co SHALL change only on the edge entering DONE and hold the last result otherwise, including during a following SHIFT.
REQ-020 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE; never both.
REQ-021 Bit counter SHALL be ceil(log2(WIDTH)) bits and SHALL not wrap within one operation.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE and Y=0, Co=0, busy=0, done=0, counter/shift/carry registers=0, and V=0 when present.
REQ-023 rst SHALL override start and any in-flight operation; an aborted operation SHALL produce no done pulse and no Y/Co update.
REQ-024 First start honoured is the one sampled on the first edge with rst=0.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: output port V (1 bit) SHALL exist, loaded with Y alongside Co = carry into bit WIDTH-1 XOR Co (two's-complement overflow), held like Y, reset to 0.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: port V and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 A=8'h3C, B=8'h5A, Ci=0, start pulse -> done 8 cycles after accepting edge, Y=8'h96, Co=0, V=1.
REQ-028 A=8'hFF, B=8'h01, Ci=0 -> Y=8'h00, Co=1, V=0; A=8'h7F, B=8'h00, Ci=1 -> Y=8'h80, Co=0, V=1.
REQ-029 Prior result Y=8'h96 held, new start A=8'h01, B=8'h01, pulse start again at SHIFT cycle 3 -> second start ignored, one done, Y stays 8'h96 until done then 8'h02.
REQ-030 rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, Y=0, Co=0; no done pulse ever follows for aborted operation.
REQ-031 start held high continuously, A=8'h10, B=8'h20, Ci=0 -> done pulses every 10 cycles, Y=8'h30, Co=0 each time.
